move_input_controller: RTL
==========================

Name: move_input_controller

Overview:
- Front-end stage feeding gameController: turns four raw direction push-buttons and a new-game button into clean single-move requests.
- Per button: synchronise, debounce, then rising-edge detect. Issues exactly one handshaked move per physical press, encoded on the 2-bit dir bus.
- Emits a one-cycle new-game pulse that drives the game's reset input.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required before a debounced level changes (10 ms at 25 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- btn_up  input  1  raw asynchronous button, active-high
- btn_right  input  1  raw asynchronous button, active-high
- btn_down  input  1  raw asynchronous button, active-high
- btn_left  input  1  raw asynchronous button, active-high
- btn_new  input  1  raw asynchronous new-game button, active-high
- move_ready  input  1  consumer accepts the current move when high
- dir  output  2  move direction: 00 up, 01 right, 10 down, 11 left
- move_valid  output  1  move request pending
- new_game  output  1  one-cycle pulse on debounced btn_new press
- busy  output  1  high in ISSUE or WAIT_RELEASE

Behaviour:
- Reset (rst low, async): all synchronisers, counters and debounced levels go to 0. FSM goes to IDLE. dir=00, move_valid=0, new_game=0, busy=0.
- Synchroniser: 2-flop per button.
- Debounce, per button:
  - Counter clears whenever the sync output equals the debounced level.
  - Otherwise the counter increments.
  - When it has differed for DEBOUNCE_CYCLES consecutive clocks, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Press event: debounced level 0->1 (registered previous level), high for one cycle.
- Latency: a clean raw rise just after edge 0 gives move_valid (or new_game) high from edge DEBOUNCE_CYCLES+3.
- FSM states: IDLE, ISSUE, WAIT_RELEASE.
  - IDLE: on any direction press event, latch dir from the pressing button, assert move_valid, go to ISSUE. Simultaneous press events use priority up > right > down > left.
  - ISSUE: move_valid stays high and dir stays stable until move_ready is sampled high. Transfer happens on that edge; move_valid drops next cycle; go to WAIT_RELEASE. Further press events in ISSUE are ignored (no queueing).
  - WAIT_RELEASE: return to IDLE only when all four debounced direction levels are 0. Holding a button never auto-repeats.
- dir holds its last issued value outside ISSUE.
- new_game:
  - One-cycle pulse on the btn_new press event, independent of FSM state.
  - In the same cycle it aborts any pending move: move_valid=0 and FSM goes to WAIT_RELEASE.
  - If the new_game and direction press events coincide, new_game wins and no move is issued.
- move_ready high while move_valid is low has no effect.
- Reset asserted mid-ISSUE drops move_valid immediately (asynchronously); no move is transferred.

Decomposition:
- Shared package game_pkg:
  - direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11, also used by gameController;
  - FSM state encoding for IDLE/ISSUE/WAIT_RELEASE.
- Sub-module button_debounce (params DEBOUNCE_CYCLES, CNT_W; ports clk, rst, raw, level, press), instantiated five times.
- The top holds the priority encoder, FSM and handshake.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- btn_right rises after edge 0 and is held, move_ready=1 -> move_valid high exactly at edge 7 for one cycle, dir=01. No second move while held. busy stays high until release is debounced.
- btn_up pulses high for 3 clocks then returns low -> debounced level never changes; move_valid, new_game and dir stay 0.
- btn_down and btn_left rise on the same cycle, move_ready=1 -> single move with dir=10. Releasing only btn_down keeps FSM in WAIT_RELEASE until btn_left is also released.
- btn_left pressed with move_ready=0 for 10 cycles, then 1 -> move_valid held 11 cycles, dir=11 stable throughout, drops on the cycle after transfer.
- btn_new pressed while in ISSUE -> new_game high for exactly one cycle, move_valid cleared that cycle, no transfer even if move_ready rises later.
- rst driven low asynchronously mid-ISSUE -> move_valid, dir, busy go to 0 before the next clock edge. After release, a fresh press issues a normal move.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: move direction codes (also used by gameController)
// and the move-input FSM state encoding.
package game_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_ISSUE        = 2'b01,
    ST_WAIT_RELEASE = 2'b10
  } mic_state_e;

  // Press vector bit order is {left, down, right, up}; lower index wins.
  function automatic dir_t pick_dir(input logic [3:0] press);
    dir_t d;
    if (press[0])      d = DIR_UP;
    else if (press[1]) d = DIR_RIGHT;
    else if (press[2]) d = DIR_DOWN;
    else if (press[3]) d = DIR_LEFT;
    else               d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/move_input_controller_if.sv
// Move request handshake between the input controller (master) and the
// game logic (slave): dir is qualified by move_valid, accepted on move_ready.
interface move_input_controller_if;
  import game_pkg::*;

  dir_t dir;
  logic move_valid;
  logic move_ready;

  modport master (
    output dir,
    output move_valid,
    input  move_ready
  );

  modport slave (
    input  dir,
    input  move_valid,
    output move_ready
  );

endinterface

// File: rtl/move_input_controller_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, counter debounce and
// rising-edge detect of the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q;

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing clock,
  // so the counter only needs to reach DEBOUNCE_CYCLES-1.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/move_input_controller.sv
// Front end for gameController: conditions four direction buttons and a
// new-game button into one handshaked move per press plus a new-game pulse.
module move_input_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_up,
  input  logic                           btn_right,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_new,
  move_input_controller_if.master        mv,
  output logic                           new_game,
  output logic                           busy
);

  logic [3:0] dir_raw;
  logic [3:0] dir_level;
  logic [3:0] dir_press;
  logic       new_press;
  logic       unused_new_level;

  assign dir_raw = {btn_left, btn_down, btn_right, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_dir_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (dir_raw[i]),
      .level (dir_level[i]),
      .press (dir_press[i])
    );
  end

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_new (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_new),
    .level (unused_new_level),
    .press (new_press)
  );

  mic_state_e state_q;
  dir_t       dir_q;
  logic       valid_q;
  logic       new_game_q;

  // new_game overrides every state so a coincident direction press is dropped
  // and any pending move is withdrawn before the consumer can take it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_UP;
      valid_q    <= '0;
      new_game_q <= '0;
    end else begin
      new_game_q <= new_press;
      if (new_press) begin
        valid_q <= '0;
        state_q <= ST_WAIT_RELEASE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (|dir_press) begin
              dir_q   <= pick_dir(dir_press);
              valid_q <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (mv.move_ready) begin
              valid_q <= '0;
              state_q <= ST_WAIT_RELEASE;
            end
          end
          ST_WAIT_RELEASE: begin
            if (dir_level == '0) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            valid_q <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mv.dir        = dir_q;
  assign mv.move_valid = valid_q;
  assign new_game      = new_game_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
